// File: rtl/ysyx_23060332_ifu_pkg.sv
// Shared IFU definitions: reset PC, NOP encoding, bus widths and FSM state encodings.
package ysyx_23060332_ifu_pkg;

  localparam int unsigned INST_BUS_W      = 32;
  localparam int unsigned INST_ADDR_BUS_W = 32;

  localparam logic [INST_ADDR_BUS_W-1:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [INST_BUS_W-1:0]      INST_NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/ysyx_23060332_pc_reg.sv
// Program counter register with next-PC selection.
//   clk, rst_n : clock, synchronous active-low reset (loads RESET_PC)
//   advance    : decode accepted the current instruction; load next PC
//   jump_flag  : select jump target instead of pc+4
//   jump_addr  : jump target; low two bits are cleared before loading
//   pc         : current program counter
module ysyx_23060332_pc_reg
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter int unsigned          XLEN     = INST_ADDR_BUS_W,
  parameter logic [XLEN-1:0]      RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_addr,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] next_pc_c;

  // Sequential PC wraps modulo 2^XLEN; jump targets are silently word-aligned.
  always_comb begin
    next_pc_c = pc + XLEN'(4);
    if (jump_flag) next_pc_c = jump_addr & ~XLEN'(3);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)       pc <= RESET_PC;
    else if (advance) pc <= next_pc_c;
  end

endmodule

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time to
// instruction memory and holds the fetched word for decode until accepted.
//   clk, rst_n                  : clock, synchronous active-low reset
//   imem_req_valid/ready, imem_addr : fetch request channel (addr = pc)
//   imem_resp_valid, imem_rdata : read response, honoured only in S_WAIT
//   jump_flag, jump_addr        : redirect, sampled only at decode handshake
//   inst_valid/ready, inst_o, inst_addr : instruction handoff to decode
// Optional YSYX_23060332_IFU_PERF_EN adds fetch_cnt (decode handshakes)
// and stall_cnt (cycles spent in S_WAIT), both 64-bit wrapping counters.
module ysyx_23060332_ifu
  import ysyx_23060332_ifu_pkg::*;
#(
  parameter int unsigned     XLEN     = INST_BUS_W,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(IFU_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_addr,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_o,
`ifdef YSYX_23060332_IFU_PERF_EN
  output logic [63:0]     fetch_cnt,
  output logic [63:0]     stall_cnt,
`endif
  output logic [XLEN-1:0] inst_addr
);

  ifu_state_e      state;
  logic [XLEN-1:0] pc;
  logic            accept_c;

  // inst_valid mirrors S_HOLD, so this is exactly the decode handshake.
  assign accept_c  = inst_valid && inst_ready;
  assign imem_addr = pc;

  ysyx_23060332_pc_reg #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (accept_c),
    .jump_flag (jump_flag),
    .jump_addr (jump_addr),
    .pc        (pc)
  );

  // Fetch FSM; handshake outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      imem_req_valid <= 1'b0;
      inst_valid     <= 1'b0;
      inst_o         <= XLEN'(INST_NOP);
      inst_addr      <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            state      <= S_HOLD;
            inst_valid <= 1'b1;
            inst_o     <= imem_rdata;
            inst_addr  <= pc;
          end
        end
        S_HOLD: begin
          if (inst_ready) begin
            state          <= S_REQ;
            inst_valid     <= 1'b0;
            imem_req_valid <= 1'b1;
          end
        end
        default: begin
          state          <= S_IDLE;
          imem_req_valid <= 1'b0;
          inst_valid     <= 1'b0;
        end
      endcase
    end
  end

`ifdef YSYX_23060332_IFU_PERF_EN
  // Performance counters: decode handshakes and memory wait cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_cnt <= 64'd0;
      stall_cnt <= 64'd0;
    end else begin
      if (accept_c)       fetch_cnt <= fetch_cnt + 64'd1;
      if (state == S_WAIT) stall_cnt <= stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Directed self-checking bench for ysyx_23060332_ifu.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
`ifdef YSYX_23060332_IFU_PERF_EN
  logic [63:0] fetch_cnt;
  logic [63:0] stall_cnt;
`endif

  int total;
  int passed;

  ysyx_23060332_ifu dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .jump_flag       (jump_flag),
    .jump_addr       (jump_addr),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_o          (inst_o),
`ifdef YSYX_23060332_IFU_PERF_EN
    .fetch_cnt       (fetch_cnt),
    .stall_cnt       (stall_cnt),
`endif
    .inst_addr       (inst_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch: request wait, optional request stall, response after
  // 'lat' S_WAIT cycles, optional decode stall, then handshake with jump.
  task automatic fetch_one(input logic [31:0] exp_addr, input logic [31:0] word,
                           input int lat, input int req_stall, input int hold,
                           input logic jf, input logic [31:0] ja,
                           input logic early, input logic jf_wait);
    int          n;
    logic [31:0] exp_next;
    n = 0;
    while (imem_req_valid !== 1'b1 && n < 20) begin tick(); n++; end
    total++; if (imem_req_valid !== 1'b1) $display("FAIL req_timeout: req_valid=%b want 1", imem_req_valid); else passed++;
    total++; if (imem_addr !== exp_addr) $display("FAIL req_addr: got %h want %h", imem_addr, exp_addr); else passed++;
    if (jf_wait) begin jump_flag = 1'b1; jump_addr = 32'h1234_5678; end
    for (int i = 0; i < req_stall; i++) begin
      imem_req_ready = 1'b0;
      tick();
      total++; if (imem_req_valid !== 1'b1 || imem_addr !== exp_addr)
        $display("FAIL req_stall: valid=%b addr=%h want 1/%h", imem_req_valid, imem_addr, exp_addr); else passed++;
    end
    imem_req_ready = 1'b1;
    if (early) begin imem_resp_valid = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
    tick();
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
      $display("FAIL wait_entry: req_valid=%b inst_valid=%b want 0/0", imem_req_valid, inst_valid); else passed++;
    for (int i = 1; i < lat; i++) tick();
    imem_resp_valid = 1'b1;
    imem_rdata = word;
    tick();
    imem_resp_valid = 1'b0;
    imem_rdata = 32'h0;
    jump_flag = 1'b0;
    jump_addr = 32'h0;
    total++; if (inst_valid !== 1'b1 || inst_o !== word || inst_addr !== exp_addr)
      $display("FAIL hold_data: valid=%b inst=%h addr=%h want 1/%h/%h", inst_valid, inst_o, inst_addr, word, exp_addr); else passed++;
    for (int i = 0; i < hold; i++) begin
      tick();
      total++; if (inst_valid !== 1'b1 || inst_o !== word || inst_addr !== exp_addr || imem_req_valid !== 1'b0)
        $display("FAIL hold_stall: valid=%b inst=%h addr=%h req=%b", inst_valid, inst_o, inst_addr, imem_req_valid); else passed++;
    end
    exp_next = jf ? (ja & 32'hFFFF_FFFC) : exp_addr + 32'd4;
    inst_ready = 1'b1;
    jump_flag = jf;
    jump_addr = ja;
    tick();
    inst_ready = 1'b0;
    jump_flag = 1'b0;
    jump_addr = 32'h0;
    total++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== exp_next)
      $display("FAIL next_req: inst_valid=%b req=%b addr=%h want 0/1/%h", inst_valid, imem_req_valid, imem_addr, exp_next); else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0)
        $display("FAIL reset_valids: inst_valid=%b req=%b want 0/0", inst_valid, imem_req_valid); else passed++;
    end
    total++; if (imem_addr !== RST_PC || inst_addr !== RST_PC || inst_o !== NOP)
      $display("FAIL reset_regs: addr=%h iaddr=%h inst=%h", imem_addr, inst_addr, inst_o); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC || inst_valid !== 1'b0)
      $display("FAIL first_req: req=%b addr=%h inst_valid=%b want 1/%h/0", imem_req_valid, imem_addr, inst_valid, RST_PC); else passed++;
  endtask

  task automatic test_sequential();
    fetch_one(32'h8000_0000, 32'h0010_0093, 1, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    fetch_one(32'h8000_0004, 32'h0020_0113, 1, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure_jump();
    fetch_one(32'h8000_0008, 32'h0030_0193, 1, 4, 5, 1'b1, 32'h8000_0103, 1'b0, 1'b0);
  endtask

  task automatic test_jump_ignored();
    fetch_one(32'h8000_0100, 32'h0040_0213, 2, 1, 0, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_early_resp();
    fetch_one(32'h8000_0104, 32'h0050_0293, 1, 0, 0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
  endtask

  task automatic test_wrap();
    fetch_one(32'hFFFF_FFFC, 32'h0060_0313, 1, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0)
      $display("FAIL wrap_req: req=%b addr=%h want 1/00000000", imem_req_valid, imem_addr); else passed++;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    imem_resp_valid = 1'b1;
    imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_resp_valid = 1'b0;
    imem_rdata = 32'h0;
    total++; if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== RST_PC || inst_o !== NOP || inst_addr !== RST_PC)
      $display("FAIL midrst: req=%b iv=%b addr=%h inst=%h iaddr=%h", imem_req_valid, inst_valid, imem_addr, inst_o, inst_addr); else passed++;
`ifdef YSYX_23060332_IFU_PERF_EN
    total++; if (fetch_cnt !== 64'd0 || stall_cnt !== 64'd0)
      $display("FAIL perf_reset: fetch=%0d stall=%0d want 0/0", fetch_cnt, stall_cnt); else passed++;
`endif
    rst_n = 1'b1;
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== RST_PC)
      $display("FAIL midrst_req: req=%b addr=%h want 1/%h", imem_req_valid, imem_addr, RST_PC); else passed++;
  endtask

  task automatic test_perf();
    logic [31:0] a;
    a = RST_PC;
    for (int i = 0; i < 10; i++) begin
      fetch_one(a, 32'h0000_0093 + 32'(i), 2, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
      a = a + 32'd4;
    end
`ifdef YSYX_23060332_IFU_PERF_EN
    total++; if (fetch_cnt !== 64'd10) $display("FAIL fetch_cnt: got %0d want 10", fetch_cnt); else passed++;
    total++; if (stall_cnt !== 64'd20) $display("FAIL stall_cnt: got %0d want 20", stall_cnt); else passed++;
`endif
  endtask

  initial begin
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata = 32'h0;
    jump_flag = 1'b0;
    jump_addr = 32'h0;
    inst_ready = 1'b0;
    #1;
    test_reset();
    test_sequential();
    test_backpressure_jump();
    test_jump_ignored();
    test_early_resp();
    test_wrap();
    test_mid_reset();
    test_perf();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
